// File: rtl/aim_pkg.sv
// Shared constants, types and the collector state encoding for the AIM match
// stage and its downstream position collector.
package aim_pkg;

  localparam int N_WORD = 32;
  localparam int POS_W  = 9;
  localparam int ITE_W  = 3;
  localparam int IDX_W  = $clog2(N_WORD);
  localparam int CNT_W  = $clog2(N_WORD) + 1;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [ITE_W-1:0] ite_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Unsigned popcount; CNT_W holds N_WORD itself so a full mask never wraps.
  function automatic logic [CNT_W-1:0] popcount(input logic [N_WORD-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_WORD; i++) begin
      c = c + CNT_W'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/aim_pos_collector_if.sv
// Result stream from the position collector to the tracking/result logic.
// Handshake: a beat transfers on a rising clk edge where o_out_valid && i_out_ready;
// once valid is raised, the beat fields stay stable until that transfer happens.
interface aim_pos_collector_if
  import aim_pkg::*;
();

  logic             o_out_valid;
  logic             i_out_ready;
  logic [IDX_W-1:0] o_out_idx;
  pos_t             o_out_pos;
  ite_t             o_out_ite;
  logic             o_out_last;

  modport master (
    output o_out_valid,
    input  i_out_ready,
    output o_out_idx,
    output o_out_pos,
    output o_out_ite,
    output o_out_last
  );

  modport slave (
    input  o_out_valid,
    output i_out_ready,
    input  o_out_idx,
    input  o_out_pos,
    input  o_out_ite,
    input  o_out_last
  );

endinterface

// File: rtl/aim_lsb_enc.sv
// Combinational lowest-set-bit priority encoder over the remaining match mask.
module aim_lsb_enc
  import aim_pkg::*;
(
  input  logic [N_WORD-1:0] i_mask,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_any,
  output logic              o_single
);

  always_comb begin
    o_idx = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N_WORD - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx = IDX_W'(i);
      end
    end
    o_any    = |i_mask;
    o_single = o_any && ((i_mask & (i_mask - N_WORD'(1))) == '0);
  end

endmodule

// File: rtl/aim_pos_collector.sv
// Captures one AIM result set on i_finish and streams its valid entries,
// lowest word index first, reporting count, completion and lost result sets.
module aim_pos_collector
  import aim_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_finish,
  input  ite_t              i_ite,
  input  logic              i_valid [N_WORD],
  input  pos_t              i_pos   [N_WORD],
  aim_pos_collector_if.master out_if,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_done,
  output logic              o_overflow,
  output state_t            o_dbg_state
);

  state_t            state_q, state_d;
  logic [N_WORD-1:0] mask_q, mask_d;
  pos_t              bank_q [N_WORD];
  pos_t              bank_d [N_WORD];
  ite_t              tag_q, tag_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic [N_WORD-1:0] in_mask;
  logic [IDX_W-1:0]  enc_idx;
  logic              enc_any;
  logic              enc_single;

  aim_lsb_enc u_enc (
    .i_mask   (mask_q),
    .o_idx    (enc_idx),
    .o_any    (enc_any),
    .o_single (enc_single)
  );

  always_comb begin
    in_mask = '0;
    for (int i = 0; i < N_WORD; i++) begin
      in_mask[i] = i_valid[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    bank_d     = bank_q;
    tag_d      = tag_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (i_finish) begin
          mask_d  = in_mask;
          bank_d  = i_pos;
          tag_d   = i_ite;
          count_d = popcount(in_mask);
          state_d = (|in_mask) ? S_SEND : S_DONE;
        end
      end
      S_SEND: begin
        // A finish here is dropped; the set being drained is never disturbed.
        if (i_finish) begin
          overflow_d = 1'b1;
        end
        if (out_if.i_out_ready) begin
          mask_d[enc_idx] = 1'b0;
          if (enc_single) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      tag_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < N_WORD; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      bank_q     <= bank_d;
      tag_q      <= tag_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs come only from registers, so ready never reaches them combinationally.
  assign out_if.o_out_valid = (state_q == S_SEND) && enc_any;
  assign out_if.o_out_idx   = enc_idx;
  assign out_if.o_out_pos   = bank_q[enc_idx];
  assign out_if.o_out_ite   = tag_q;
  assign out_if.o_out_last  = (state_q == S_SEND) && enc_single;

  assign o_busy      = (state_q == S_SEND);
  assign o_count     = count_q;
  assign o_done      = (state_q == S_DONE);
  assign o_overflow  = overflow_q;
  assign o_dbg_state = state_q;

endmodule

// File: doc/aim_pos_collector.md
Name: aim_pos_collector

Overview:
- Downstream consumer of the AIM match stage.
- On AIM's finish pulse, captures the 32-entry valid mask, the 32 match positions and the iteration tag.
- Serialises only the valid entries, lowest word index first, over a valid/ready stream to the tracking/result logic.
- Reports the match count per iteration and flags AIM results lost while a previous result set is still draining.

Parameters:
- N_WORD, 32, number of word lanes produced by AIM (power of two).
- POS_W, 9, width of each match position.
- ITE_W, 3, width of the iteration tag.
- IDX_W, $clog2(N_WORD) = 5, width of the emitted word index.
- CNT_W, $clog2(N_WORD)+1 = 6, width of the match counter.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_finish  in  1  one-cycle pulse from AIM: i_valid, i_pos and i_ite are valid this cycle.
- i_ite  in  ITE_W  iteration tag of the AIM result.
- i_valid  in  N_WORD x 1 (unpacked [0:N_WORD-1])  per-word match flag.
- i_pos  in  N_WORD x POS_W (unpacked [0:N_WORD-1])  per-word match position.
- o_busy  out  1  high while a captured set is draining; AIM must not be restarted.
- o_out_valid  out  1  stream beat valid.
- i_out_ready  in  1  downstream accepts the beat.
- o_out_idx  out  IDX_W  word index of the current beat.
- o_out_pos  out  POS_W  position of the current beat.
- o_out_ite  out  ITE_W  iteration tag of the current set.
- o_out_last  out  1  current beat is the final valid entry of the set.
- o_count  out  CNT_W  popcount of the last captured mask; held until the next capture.
- o_done  out  1  one-cycle pulse when a set has been completely emitted, including empty sets.
- o_overflow  out  1  sticky; an i_finish arrived while in SEND.

Behaviour:
- Reset (async, i_rst=1): state=IDLE. All outputs 0. Mask, position bank and tag registers cleared.
- States: IDLE, SEND, DONE.
- Capture:
  - In IDLE or DONE, i_finish=1 registers mask<=i_valid, bank<=i_pos, tag<=i_ite, o_count<=popcount(i_valid).
  - If the mask is nonzero, next state is SEND. If the mask is zero, next state is DONE (o_done pulses with o_count=0).
- Latency: i_finish at edge t gives o_out_valid=1 from edge t+1.
- SEND:
  - o_out_valid=1.
  - o_out_idx = lowest set bit of the remaining mask; o_out_pos = bank[o_out_idx]; o_out_ite = tag.
  - o_out_last=1 when exactly one bit of the mask remains.
  - On o_out_valid && i_out_ready, clear that mask bit. If it was the last bit, go to DONE; otherwise the next beat follows the next cycle.
  - Throughput is one beat per cycle while i_out_ready=1.
- Backpressure: while o_out_valid && !i_out_ready, o_out_idx, o_out_pos, o_out_ite and o_out_last hold stable. There is no combinational path from i_out_ready to any output.
- DONE:
  - o_done=1 for exactly one cycle; o_out_valid=0; next state IDLE.
  - An i_finish in DONE is accepted (back-to-back sets). o_done still pulses that cycle.
- o_busy = (state==SEND).
- i_finish while in SEND:
  - Ignored: mask, bank, tag and count are untouched.
  - o_overflow<=1, cleared only by reset.
  - A simultaneous final handshake does not change this; the set in SEND completes normally.
- Reset asserted mid-SEND: the stream aborts immediately, o_out_valid drops asynchronously, and no o_done is issued.
- Arithmetic: popcount is unsigned. A full mask gives 32, so CNT_W is 6 bits and never wraps. Positions pass through unmodified.

Decomposition:
- Shared package aim_pkg holds:
  - Constants N_WORD=32, POS_W=9, ITE_W=3.
  - typedef pos_t = logic [POS_W-1:0].
  - typedef ite_t = logic [ITE_W-1:0].
  - The collector state enum {S_IDLE, S_SEND, S_DONE}.
- One natural sub-module: aim_lsb_enc, a combinational lowest-set-bit priority encoder.
  - Input: N_WORD mask.
  - Outputs: IDX_W index, any flag, single-bit flag.
  - It drives o_out_idx and o_out_last.

Test Plan:
- Reset mid-operation: assert i_rst while in SEND -> o_out_valid drops immediately, no o_done; after release, state is IDLE and all outputs are 0.
- Sparse set, ready=1: i_finish with i_ite=3, valid bits {2,7,31}, pos[2]=5, pos[7]=300, pos[31]=511 -> beats (2,5), (7,300), (31,511) on consecutive cycles starting t+1; o_out_last only on the third beat; o_out_ite=3; o_count=3; o_done one cycle after the third beat.
- Empty set: i_finish with all valid=0 -> o_out_valid never rises; o_done pulses at t+1; o_count=0.
- Backpressure: full mask with pos[i]=i, i_out_ready toggling 1,0,0,1,... -> beat values hold during stalls; 32 beats with idx 0..31 in order; o_count=32; o_out_last only on idx 31.
- Overflow: second i_finish during SEND -> o_overflow=1 and stays 1; the first set's beats are unaltered; the second set is never emitted.
- Back-to-back: new i_finish in the o_done cycle -> o_done pulses, then new beats from the next cycle with the new i_ite; o_overflow stays 0.
